// File: rtl/llsc_atomic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llsc_atomic_unit_pkg
// Brief    : State encoding, op codes and enable constants shared by the
//            ll/sc memory-stage engine.
// Revision : 1.0 - initial release
// ============================================================================
package llsc_atomic_unit_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_LL_BUS = 2'd1;
    localparam logic [STATE_W-1:0] ST_SC_BUS = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_LL   = 2'd1,
        OP_SC   = 2'd2
    } op_code_e;

    // What the DONE cycle reports, which decides the LLbit write.
    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_LL      = 2'd1,
        RES_SC_OK   = 2'd2,
        RES_SC_FAIL = 2'd3
    } done_kind_e;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    function automatic op_code_e decode_op(input logic valid, input logic ll, input logic sc);
        op_code_e op;
        op = OP_NONE;
        if (valid && ll) begin
            op = OP_LL;
        end else if (valid && sc) begin
            op = OP_SC;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llsc_resv_cmp.sv
`default_nettype none
// ============================================================================
// Module   : llsc_resv_cmp
// Brief    : Granule comparator between an address and the reservation.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_resv_cmp
    import llsc_atomic_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2
) (
    input  logic                       i_valid,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [ADDR_W-GRAN_LSB-1:0] i_resv_addr,
    output logic                       o_hit
);

    assign o_hit = i_valid && (i_addr[ADDR_W-1:GRAN_LSB] == i_resv_addr);

    // Offset bits within a granule never participate in the match.
    generate
        if (GRAN_LSB > 0) begin : g_unused_low
            logic unused_low_bits;
            assign unused_low_bits = ^i_addr[GRAN_LSB-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/llsc_atomic_unit.sv
`default_nettype none
// ============================================================================
// Module   : llsc_atomic_unit
// Brief    : MIPS32 ll/sc memory-stage engine: bus access, reservation
//            tracking, snoop invalidation and LLbit write port.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_atomic_unit
    import llsc_atomic_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int GRAN_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid,
    input  logic              op_ll,
    input  logic              op_sc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              llbit_i,
    input  logic              wb_llbit_we,
    input  logic              wb_llbit_value,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              llbit_we_o,
    output logic              llbit_value_o
);

    localparam int RESV_W = ADDR_W - GRAN_LSB;

    logic [STATE_W-1:0] state_q, state_d;
    logic [RESV_W-1:0]  resv_addr_q, resv_addr_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    done_kind_e         done_kind_q, done_kind_d;

    logic               w_eff_llbit;
    logic               w_resv_hit;
    logic               w_snoop_hit;
    logic               w_done;
    logic               w_done_llbit_we;
    op_code_e           w_op;

    assign w_eff_llbit = wb_llbit_we ? wb_llbit_value : llbit_i;
    assign w_op        = decode_op(op_valid, op_ll, op_sc);

    llsc_resv_cmp #(
        .ADDR_W   (ADDR_W),
        .GRAN_LSB (GRAN_LSB)
    ) u_resv_cmp (
        .i_valid     (1'b1),
        .i_addr      (addr),
        .i_resv_addr (resv_addr_q),
        .o_hit       (w_resv_hit)
    );

    llsc_resv_cmp #(
        .ADDR_W   (ADDR_W),
        .GRAN_LSB (GRAN_LSB)
    ) u_snoop_cmp (
        .i_valid     (snoop_valid),
        .i_addr      (snoop_addr),
        .i_resv_addr (resv_addr_q),
        .o_hit       (w_snoop_hit)
    );

    always_comb begin
        state_d     = state_q;
        resv_addr_d = resv_addr_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rd_data_d   = rd_data_q;
        done_kind_d = done_kind_q;

        // Flush outranks a same-cycle ack; later acks land in IDLE and are dropped.
        if (flush) begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_op == OP_LL) begin
                        state_d     = ST_LL_BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = addr;
                        bus_wdata_d = wdata;
                    end else if (w_op == OP_SC) begin
                        if (w_eff_llbit && w_resv_hit && !w_snoop_hit) begin
                            state_d     = ST_SC_BUS;
                            bus_req_d   = 1'b1;
                            bus_we_d    = 1'b1;
                            bus_addr_d  = addr;
                            bus_wdata_d = wdata;
                        end else begin
                            state_d     = ST_DONE;
                            rd_data_d   = '0;
                            done_kind_d = RES_SC_FAIL;
                        end
                    end
                end
                ST_LL_BUS: begin
                    if (bus_ack) begin
                        state_d     = ST_DONE;
                        bus_req_d   = 1'b0;
                        rd_data_d   = bus_rdata;
                        resv_addr_d = bus_addr_q[ADDR_W-1:GRAN_LSB];
                        done_kind_d = RES_LL;
                    end
                end
                ST_SC_BUS: begin
                    // A snoop here does not cancel the store already on the bus.
                    if (bus_ack) begin
                        state_d     = ST_DONE;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        rd_data_d   = {{(DATA_W-1){1'b0}}, 1'b1};
                        done_kind_d = RES_SC_OK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_IDLE;
            resv_addr_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            done_kind_q <= RES_NONE;
        end else begin
            state_q     <= state_d;
            resv_addr_q <= resv_addr_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rd_data_q   <= rd_data_d;
            done_kind_q <= done_kind_d;
        end
    end

    assign w_done          = (state_q == ST_DONE) && !flush;
    assign w_done_llbit_we = w_done && ((done_kind_q == RES_LL) || (done_kind_q == RES_SC_OK));

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = w_done;

    assign stall_req = ((state_q == ST_IDLE) && op_valid) ||
                       (state_q == ST_LL_BUS) || (state_q == ST_SC_BUS);

    // A snoop hit on the reservation always overrides the DONE write with 0.
    assign llbit_we_o    = !flush && (w_done_llbit_we || (w_snoop_hit && w_eff_llbit))
                           ? WRITE_ENABLE : WRITE_DISABLE;
    assign llbit_value_o = llbit_we_o && w_done && (done_kind_q == RES_LL) && !w_snoop_hit;

endmodule
`default_nettype wire

// File: tb/tb_llsc_atomic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_llsc_atomic_unit
// Brief    : Directed and randomized checks of llsc_atomic_unit against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llsc_atomic_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GL = 2;

    logic          clk = 1'b0;
    logic          rst, flush, op_valid, op_ll, op_sc;
    logic [AW-1:0] addr, snoop_addr, bus_addr;
    logic [DW-1:0] wdata, bus_wdata, bus_rdata, rd_data;
    logic          llbit_i, wb_llbit_we, wb_llbit_value, snoop_valid;
    logic          bus_req, bus_we, bus_ack, stall_req, rd_valid;
    logic          llbit_we_o, llbit_value_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    llsc_atomic_unit #(.ADDR_W(AW), .DATA_W(DW), .GRAN_LSB(GL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ll(op_ll),
        .op_sc(op_sc), .addr(addr), .wdata(wdata), .llbit_i(llbit_i),
        .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_req(stall_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .llbit_we_o(llbit_we_o),
        .llbit_value_o(llbit_value_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy = 0;        // a bus access is outstanding
    bit          m_bus_sc = 0;
    logic [31:0] m_bus_addr = '0, m_bus_wdata = '0;
    bit          m_done = 0;        // a result is due this cycle
    logic [31:0] m_done_data = '0;
    bit          m_done_wr = 0, m_done_ll = 0;
    logic [31:0] m_resv = '0;       // reservation granule number
    bit          m_llbit_nxt = 0;   // LLbit register value for next cycle

    initial begin
        bit eff, s_hit, idle, e_stall, e_rdv, e_we, e_val;
        @(posedge clk);
        forever begin
            @(negedge clk);
            eff     = wb_llbit_we ? wb_llbit_value : llbit_i;
            s_hit   = snoop_valid && ((snoop_addr >> GL) == m_resv);
            idle    = !m_busy && !m_done;
            e_stall = (idle && op_valid) || m_busy;
            e_rdv   = m_done && !flush;
            e_we    = !flush && ((m_done && m_done_wr) || (s_hit && eff));
            e_val   = m_done && m_done_ll && !s_hit;

            chk("m_stall_req", {31'd0, stall_req}, {31'd0, e_stall});
            chk("m_bus_req", {31'd0, bus_req}, {31'd0, m_busy});
            chk("m_rd_valid", {31'd0, rd_valid}, {31'd0, e_rdv});
            chk("m_llbit_we", {31'd0, llbit_we_o}, {31'd0, e_we});
            if (e_we) chk("m_llbit_value", {31'd0, llbit_value_o}, {31'd0, e_val});
            if (e_rdv) chk("m_rd_data", rd_data, m_done_data);
            if (m_busy) begin
                chk("m_bus_we", {31'd0, bus_we}, {31'd0, m_bus_sc});
                chk("m_bus_addr", bus_addr, m_bus_addr);
                if (m_bus_sc) chk("m_bus_wdata", bus_wdata, m_bus_wdata);
            end

            m_llbit_nxt = rst ? 1'b0 : flush ? 1'b0 : e_we ? e_val :
                          wb_llbit_we ? wb_llbit_value : llbit_i;

            if (rst) begin
                m_busy = 0; m_done = 0; m_resv = '0;
            end else if (flush) begin
                m_busy = 0; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (bus_ack) begin
                    m_busy = 0; m_done = 1; m_done_wr = 1;
                    m_done_ll = !m_bus_sc;
                    if (m_bus_sc) m_done_data = 32'd1;
                    else begin
                        m_done_data = bus_rdata;
                        m_resv = m_bus_addr >> GL;
                    end
                end
            end else if (op_valid && op_ll) begin
                m_busy = 1; m_bus_sc = 0; m_bus_addr = addr; m_bus_wdata = wdata;
            end else if (op_valid && op_sc) begin
                if (eff && ((addr >> GL) == m_resv) && !s_hit) begin
                    m_busy = 1; m_bus_sc = 1; m_bus_addr = addr; m_bus_wdata = wdata;
                end else begin
                    m_done = 1; m_done_wr = 0; m_done_ll = 0; m_done_data = '0;
                end
            end
        end
    end

    // LLbit register of the surrounding pipeline
    initial begin
        llbit_i = 1'b0;
        forever begin
            @(posedge clk);
            #1 llbit_i = m_llbit_nxt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_op(input bit v, input bit ll, input bit sc, input logic [31:0] a,
                            input logic [31:0] d);
        op_valid = v; op_ll = ll; op_sc = sc; addr = a; wdata = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stalls;
        int ack_cnt;
        logic [31:0] pool [4];
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h0;

        rst = 1; flush = 0; drive_op(0, 0, 0, '0, '0);
        wb_llbit_we = 0; wb_llbit_value = 0; snoop_valid = 0; snoop_addr = '0;
        bus_ack = 0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        smp();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_llbit_we", {31'd0, llbit_we_o}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // ll 0x100, ack in the third bus cycle
        step(); drive_op(1, 1, 0, 32'h100, 32'h0);
        smp(); stalls = int'(stall_req);
        step(); drive_op(0, 0, 0, 32'h0, 32'h0);
        smp(); stalls += int'(stall_req);
        chk("ll_bus_req", {31'd0, bus_req}, 32'd1);
        chk("ll_bus_we", {31'd0, bus_we}, 32'd0);
        chk("ll_bus_addr", bus_addr, 32'h100);
        step();
        smp(); stalls += int'(stall_req);
        step(); bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        smp(); stalls += int'(stall_req);
        step(); bus_ack = 0;
        smp(); stalls += int'(stall_req);
        chk("ll_stall_cycles", stalls, 32'd4);
        chk("ll_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("ll_rd_data", rd_data, 32'hDEADBEEF);
        chk("ll_llbit_we", {31'd0, llbit_we_o}, 32'd1);
        chk("ll_llbit_value", {31'd0, llbit_value_o}, 32'd1);

        // sc 0x100 succeeds
        step(); drive_op(1, 0, 1, 32'h100, 32'h55);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0); bus_ack = 1;
        smp();
        chk("sc_bus_we", {31'd0, bus_we}, 32'd1);
        chk("sc_bus_addr", bus_addr, 32'h100);
        chk("sc_bus_wdata", bus_wdata, 32'h55);
        step(); bus_ack = 0;
        smp();
        chk("sc_rd_data", rd_data, 32'd1);
        chk("sc_llbit_we", {31'd0, llbit_we_o}, 32'd1);
        chk("sc_llbit_value", {31'd0, llbit_value_o}, 32'd0);

        // sc 0x104 fails locally
        step(); drive_op(1, 0, 1, 32'h104, 32'h77);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0);
        smp();
        chk("scf_bus_req", {31'd0, bus_req}, 32'd0);
        chk("scf_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("scf_rd_data", rd_data, 32'd0);
        chk("scf_llbit_we", {31'd0, llbit_we_o}, 32'd0);

        // ll 0x200, snoop 0x202 kills it, sc 0x200 fails
        step(); drive_op(1, 1, 0, 32'h200, 32'h0);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0); bus_ack = 1; bus_rdata = 32'h12345678;
        smp();
        step(); bus_ack = 0;
        smp();
        step(); snoop_valid = 1; snoop_addr = 32'h202;
        smp();
        chk("snp_llbit_we", {31'd0, llbit_we_o}, 32'd1);
        chk("snp_llbit_value", {31'd0, llbit_value_o}, 32'd0);
        step(); snoop_valid = 0; drive_op(1, 0, 1, 32'h200, 32'h9);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0);
        smp();
        chk("snp_sc_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("snp_sc_rd_data", rd_data, 32'd0);

        // forwarded LLbit=0 forces sc failure
        step(); drive_op(1, 1, 0, 32'h300, 32'h0);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0); bus_ack = 1; bus_rdata = 32'h1;
        smp();
        step(); bus_ack = 0;
        smp();
        step(); drive_op(1, 0, 1, 32'h300, 32'h5); wb_llbit_we = 1; wb_llbit_value = 0;
        smp();
        chk("fwd_llbit_i", {31'd0, llbit_i}, 32'd1);
        step(); drive_op(0, 0, 0, 32'h0, 32'h0); wb_llbit_we = 0;
        smp();
        chk("fwd_bus_req", {31'd0, bus_req}, 32'd0);
        chk("fwd_rd_data", rd_data, 32'd0);

        // flush during LL bus access, then a late ack
        step(); drive_op(1, 1, 0, 32'h400, 32'h0);
        smp();
        step(); drive_op(0, 0, 0, 32'h0, 32'h0); flush = 1;
        smp();
        chk("fl_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("fl_llbit_we", {31'd0, llbit_we_o}, 32'd0);
        step(); flush = 0; bus_ack = 1;
        smp();
        chk("fl_bus_req", {31'd0, bus_req}, 32'd0);
        step(); bus_ack = 0;
        smp();
        chk("fl_late_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("fl_late_llbit_we", {31'd0, llbit_we_o}, 32'd0);

        // randomized traffic with an autonomous bus responder
        ack_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            op_valid = ($urandom_range(0, 1) == 1);
            op_ll = ($urandom_range(0, 1) == 1);
            op_sc = !op_ll;
            addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            wdata = $urandom;
            flush = ($urandom_range(0, 19) == 0);
            wb_llbit_we = ($urandom_range(0, 5) == 0);
            wb_llbit_value = ($urandom_range(0, 1) == 1);
            snoop_valid = ($urandom_range(0, 7) == 0);
            snoop_addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            bus_ack = 0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    bus_ack = 1;
                    bus_rdata = $urandom;
                end
            end else if (bus_req) begin
                ack_cnt = $urandom_range(1, 4);
            end
        end

        step();
        drive_op(0, 0, 0, '0, '0); flush = 0; bus_ack = 0;
        snoop_valid = 0; wb_llbit_we = 0;
        repeat (3) smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/llsc_atomic_unit.md
Name: llsc_atomic_unit

Overview:
Memory-stage engine for MIPS32 ll/sc that consumes the LLbit register value and drives its write port. It issues the ll load and the conditional sc store over the data bus with a req/ack handshake, and holds the reservation address. It clears the reservation on snooped stores and returns the sc success flag. It stalls the pipeline while an atomic bus access is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
GRAN_LSB, 2, low address bits ignored in reservation compare (word granule)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  exception flush; abort current op
op_valid  in  1  mem-stage atomic op present
op_ll  in  1  op is ll (exclusive with op_sc)
op_sc  in  1  op is sc
addr  in  ADDR_W  effective address
wdata  in  DATA_W  sc store data
llbit_i  in  1  current LLbit register value
wb_llbit_we  in  1  WB-stage LLbit write pending (forwarding)
wb_llbit_value  in  1  WB-stage LLbit value
snoop_valid  in  1  external/other-master store observed
snoop_addr  in  ADDR_W  snooped store address
bus_req  out  1  bus request
bus_we  out  1  1 = write (sc), 0 = read (ll)
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_ack  in  1  bus completion, one-cycle pulse
bus_rdata  in  DATA_W  read data, valid with bus_ack
stall_req  out  1  hold pipeline
rd_valid  out  1  result valid, one-cycle pulse
rd_data  out  DATA_W  ll load data or sc flag (1/0)
llbit_we_o  out  1  LLbit write enable
llbit_value_o  out  1  LLbit write value

Behaviour:
- Reset: state IDLE; resv_addr 0; all outputs 0.
- eff_llbit = wb_llbit_we ? wb_llbit_value : llbit_i (combinational forward).
- resv_hit = addr[ADDR_W-1:GRAN_LSB] == resv_addr.
- snoop_hit = snoop_valid && snoop_addr[ADDR_W-1:GRAN_LSB] == resv_addr.
- States: IDLE, LL_BUS, SC_BUS, DONE.
- IDLE:
  - op_valid&op_ll -> LL_BUS.
  - op_valid&op_sc: if eff_llbit && resv_hit && !snoop_hit -> SC_BUS; else -> DONE with rd_data=0 (no bus access).
  - stall_req = op_valid (combinational) in IDLE.
- LL_BUS/SC_BUS:
  - bus_req=1, registered addr/data held stable until bus_ack; bus_we=0 for LL_BUS, 1 for SC_BUS.
  - stall_req=1.
  - On bus_ack -> DONE, with bus_req=0 in the same registered update.
  - LL: rd_data=bus_rdata; resv_addr<=addr granule.
  - SC: rd_data=1.
- DONE (exactly 1 cycle):
  - rd_valid=1, stall_req=0, -> IDLE.
  - llbit_we_o=1, with llbit_value_o=1 after ll, 0 after sc success; no LLbit write on sc fail.
- Snoop:
  - In any state, snoop_hit && eff_llbit -> llbit_we_o=1, value 0 that cycle.
  - If this coincides with a DONE LL write to the same granule, the snoop wins (value 0).
  - In SC_BUS, a snoop does not abort the issued store: bus order, sc still succeeds.
- Flush:
  - Synchronous, any state -> IDLE next cycle; bus_req drops next cycle.
  - An ack arriving after flush is ignored.
  - rd_valid and llbit_we_o are suppressed in the flush cycle; the LLbit register clears itself.
- rst has priority over flush, which has priority over bus_ack.
- Back-to-back ops: a new op is sampled only in IDLE; the DONE cycle always separates accesses.

Decomposition:
- Shared package/defines: state encoding (IDLE=2'd0, LL_BUS=1, SC_BUS=2, DONE=3), op codes for ll/sc, and WriteEnable/RstEnable constants.
- One natural sub-module: llsc_resv_cmp, the combinational granule comparator used for both resv_hit and snoop_hit.

Test Plan:
- ll 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall 4 cycles; DONE rd_data=0xDEADBEEF, llbit_we_o=1, value 1.
- ll 0x100 then sc 0x100, wdata 0x55, llbit_i=1 -> bus_we=1, addr 0x100; on ack rd_data=1, llbit write 0.
- sc 0x104 with resv 0x100, or llbit_i=0 -> no bus_req; next cycle rd_data=0, rd_valid=1, no LLbit write.
- ll 0x200 done, then snoop store 0x202 -> llbit_we_o=1, value 0; subsequent sc 0x200 fails with 0.
- sc in IDLE with wb_llbit_we=1, wb_llbit_value=0 while llbit_i=1 -> forwarding forces fail, rd_data=0.
- flush during LL_BUS before ack, late ack pulse -> IDLE, bus_req low next cycle, no rd_valid, no llbit write.
